axis_sample_uart_tx: RTL and testbench

//  AXI4-Stream sink that takes each filtered signed ECG sample from the bandpass filter's master

---
 rtl/axis_sample_uart_tx.sv | 142 ++++++++++++++
 tb/tb_axis_sample_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_uart_tx.sv
// rtl/axis_sample_uart_tx.sv - AXI4-Stream sample sink serialising each 16-bit sample as 8N1 UART bytes
//
// Ports:
//   clk            fabric clock, all logic on rising edge
//   rst_n          synchronous active-low reset
//   s_axis_tvalid  sample valid (may be a single-cycle pulse)
//   s_axis_tdata   signed sample, two's complement
//   s_axis_tready  registered; high only while idle and able to accept
//   uart_tx        serial line, idle high
//   busy           frame in progress
//   drop_cnt       saturating count of tvalid rises seen while not ready
//
// Frame: [sync_byte,] tdata[15:8], tdata[7:0]; each byte start + 8 data (LSB first) + stop.
module axis_sample_uart_tx #(
  parameter int         clk_freq_hz = 50_000_000,
  parameter int         baud        = 115200,
  parameter int         inout_width = 16,
  parameter bit         send_sync   = 1'b1,
  parameter logic [7:0] sync_byte   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  input  logic [inout_width-1:0] s_axis_tdata,
  output logic                   s_axis_tready,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam int clks_per_bit = clk_freq_hz / baud;
  localparam int cnt_w = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(clks_per_bit - 1);
  localparam logic [1:0] last_byte = send_sync ? 2'd2 : 2'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [cnt_w-1:0]       bit_cnt;
  logic [2:0]             bit_idx;
  logic [1:0]             byte_idx;
  logic [inout_width-1:0] hold;
  logic [7:0]             shifter;
  logic                   tvalid_d;
  logic                   bit_end;
  logic                   drop_rise;
  logic [7:0]             cur_byte;

  assign bit_end = (bit_cnt == cnt_last);

  // A rise while idle-but-not-yet-ready (after reset or on frame-end re-entry)
  // is about to be accepted, so it is not counted as a drop.
  assign drop_rise = s_axis_tvalid && !tvalid_d && !s_axis_tready && (state != IDLE);

  always_comb begin
    cur_byte = hold[7:0];
    if (send_sync) begin
      if (byte_idx == 2'd0)      cur_byte = sync_byte;
      else if (byte_idx == 2'd1) cur_byte = hold[15:8];
    end else if (byte_idx == 2'd0) begin
      cur_byte = hold[15:8];
    end
  end

  // uart_tx is registered from the state seen at each edge, so the line trails
  // the state by one cycle: the start bit appears one edge after the handshake
  // and the final stop bit ends one edge after the state returns to IDLE, which
  // is exactly when tready is re-asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      uart_tx       <= 1'b1;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      drop_cnt      <= 8'd0;
      bit_cnt       <= '0;
      bit_idx       <= 3'd0;
      byte_idx      <= 2'd0;
      hold          <= '0;
      shifter       <= 8'd0;
      tvalid_d      <= 1'b0;
    end else begin
      tvalid_d <= s_axis_tvalid;
      if (drop_rise && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          bit_cnt <= '0;
          if (s_axis_tready && s_axis_tvalid) begin
            hold          <= s_axis_tdata;
            byte_idx      <= 2'd0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b1;
            state         <= START;
          end else begin
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        START: begin
          uart_tx <= 1'b0;
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            shifter <= cur_byte;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + cnt_w'(1);
          end
        end
        DATA: begin
          uart_tx <= shifter[0];
          if (bit_end) begin
            bit_cnt <= '0;
            shifter <= {1'b0, shifter[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            bit_cnt <= bit_cnt + cnt_w'(1);
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_idx == last_byte) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= START;
            end
          end else begin
            bit_cnt <= bit_cnt + cnt_w'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sample_uart_tx.sv
// tb/tb_axis_sample_uart_tx.sv - scoreboard bench for axis_sample_uart_tx (sync and no-sync instances)
module tb_axis_sample_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 125_000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0 = 1'b0, rst_n1 = 1'b0;
  logic        tvalid0 = 1'b0, tvalid1 = 1'b0;
  logic [15:0] tdata0 = 16'h0, tdata1 = 16'h0;
  logic        tready0, tready1, tx0, tx1, busy0, busy1;
  logic [7:0]  drop0, drop1;

  axis_sample_uart_tx #(.clk_freq_hz(CLK_HZ), .baud(BAUD), .inout_width(16),
                        .send_sync(1'b1), .sync_byte(8'hA5)) u_sync (
    .clk(clk), .rst_n(rst_n0), .s_axis_tvalid(tvalid0), .s_axis_tdata(tdata0),
    .s_axis_tready(tready0), .uart_tx(tx0), .busy(busy0), .drop_cnt(drop0));

  axis_sample_uart_tx #(.clk_freq_hz(CLK_HZ), .baud(BAUD), .inout_width(16),
                        .send_sync(1'b0), .sync_byte(8'hA5)) u_nosync (
    .clk(clk), .rst_n(rst_n1), .s_axis_tvalid(tvalid1), .s_axis_tdata(tdata1),
    .s_axis_tready(tready1), .uart_tx(tx1), .busy(busy1), .drop_cnt(drop1));

  int       vectors = 0;
  int       miscompares = 0;
  bit [7:0] expq[2][$];
  bit       abort[2];
  int       exp_drop[2];

  function automatic logic rd_tx(int d);      return (d == 0) ? tx0 : tx1;         endfunction
  function automatic logic rd_ready(int d);   return (d == 0) ? tready0 : tready1; endfunction
  function automatic logic rd_busy(int d);    return (d == 0) ? busy0 : busy1;     endfunction
  function automatic logic [7:0] rd_drop(int d); return (d == 0) ? drop0 : drop1;  endfunction
  function automatic int frame_len(int d);    return ((d == 0) ? 3 : 2) * 10 * CPB; endfunction

  task automatic set_in(int d, logic v, logic [15:0] data);
    if (d == 0) begin tvalid0 = v; tdata0 = data; end
    else begin tvalid1 = v; tdata1 = data; end
  endtask

  task automatic set_rst(int d, logic v);
    if (d == 0) rst_n0 = v; else rst_n1 = v;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the bytes a sample must produce on the line.
  task automatic push_sample(int d, int val);
    int v;
    v = val & 'hFFFF;
    if (d == 0) expq[d].push_back(8'hA5);
    expq[d].push_back(8'(v / 256));
    expq[d].push_back(8'(v % 256));
  endtask

  task automatic wait_ready(int d);
    int t;
    t = 0;
    @(negedge clk);
    while (rd_ready(d) !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (rd_ready(d) !== 1'b1) chk($sformatf("ready_timeout_dut%0d", d), 32'(rd_ready(d)), 1);
  endtask

  // mode 0: plain frame; 1: one extra pulse during byte 1; 2: pulse every
  // other cycle through the frame; 3: reset during data bit 5 of byte 1.
  task automatic send(int d, int val, int mode);
    int nf, p_at, r_at;
    nf   = frame_len(d);
    p_at = 1 + 10 * CPB + 3;
    r_at = 1 + 16 * CPB + 2;
    wait_ready(d);
    set_in(d, 1'b1, val[15:0]);
    @(posedge clk);
    #1 set_in(d, 1'b0, val[15:0]);
    push_sample(d, val);
    for (int n = 0; n <= nf + 1; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk($sformatf("tx_high_at_handshake_dut%0d", d), 32'(rd_tx(d)), 1);
        chk($sformatf("busy_set_dut%0d", d), 32'(rd_busy(d)), 1);
        chk($sformatf("ready_cleared_dut%0d", d), 32'(rd_ready(d)), 0);
      end
      if (n == 1) chk($sformatf("start_bit_dut%0d", d), 32'(rd_tx(d)), 0);
      if (mode == 1 && n == p_at) begin
        set_in(d, 1'b1, 16'h1234);
        if (exp_drop[d] < 255) exp_drop[d]++;
      end
      if (mode == 1 && n == p_at + 1) set_in(d, 1'b0, 16'h1234);
      if (mode == 2 && n >= 2 && n <= nf - 3) begin
        if (n % 2 == 0 && n <= nf - 4) begin
          set_in(d, 1'b1, 16'h1234);
          if (exp_drop[d] < 255) exp_drop[d]++;
        end else begin
          set_in(d, 1'b0, 16'h1234);
        end
      end
      if (mode == 3 && n == r_at) begin
        abort[d] = 1'b1;
        expq[d].delete();
        set_rst(d, 1'b0);
        @(negedge clk);
        chk($sformatf("reset_tx_high_dut%0d", d), 32'(rd_tx(d)), 1);
        chk($sformatf("reset_ready_dut%0d", d), 32'(rd_ready(d)), 0);
        chk($sformatf("reset_busy_dut%0d", d), 32'(rd_busy(d)), 0);
        chk($sformatf("reset_drop_dut%0d", d), 32'(rd_drop(d)), 0);
        exp_drop[d] = 0;
        set_rst(d, 1'b1);
        @(negedge clk);
        chk($sformatf("ready_after_release_dut%0d", d), 32'(rd_ready(d)), 1);
        repeat (2) @(negedge clk);
        abort[d] = 1'b0;
        return;
      end
      if (n == nf) begin
        chk($sformatf("ready_low_last_cycle_dut%0d", d), 32'(rd_ready(d)), 0);
        chk($sformatf("busy_high_last_cycle_dut%0d", d), 32'(rd_busy(d)), 1);
      end
      if (n == nf + 1) begin
        chk($sformatf("ready_reentry_dut%0d", d), 32'(rd_ready(d)), 1);
        chk($sformatf("busy_clear_dut%0d", d), 32'(rd_busy(d)), 0);
        chk($sformatf("drop_cnt_dut%0d", d), 32'(rd_drop(d)), 32'(exp_drop[d]));
      end
    end
  endtask

  // UART monitor: every bit must hold one level for exactly CPB samples.
  task automatic monitor(int d);
    bit       aborted, glitch;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (!abort[d] && rd_tx(d) === 1'b0) begin
        aborted = 1'b0;
        glitch  = 1'b0;
        bits    = '0;
        for (int j = 0; j < 10 && !aborted; j++) begin
          for (int s = 0; s < CPB; s++) begin
            if (j != 0 || s != 0) @(negedge clk);
            if (abort[d]) begin aborted = 1'b1; break; end
            if (s == 0) bits[j] = rd_tx(d);
            else if (rd_tx(d) !== bits[j]) glitch = 1'b1;
          end
        end
        if (!aborted) begin
          chk($sformatf("bit_timing_dut%0d", d), 32'(glitch), 0);
          chk($sformatf("stop_bit_dut%0d", d), 32'(bits[9]), 1);
          if (expq[d].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte_dut%0d: got 0x%0h expected none", d, bits[8:1]);
          end else begin
            chk($sformatf("byte_dut%0d", d), 32'(bits[8:1]), 32'(expq[d].pop_front()));
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bvals[6];
    int v;
    bvals = '{'h8000, 'h7FFF, 'h0000, 'hFFFF, 'h00FF, 'hFF00};
    abort[0] = 1'b0;
    abort[1] = 1'b0;
    exp_drop[0] = 0;
    exp_drop[1] = 0;

    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_tx_dut%0d", d), 32'(rd_tx(d)), 1);
      chk($sformatf("rst_ready_dut%0d", d), 32'(rd_ready(d)), 0);
      chk($sformatf("rst_busy_dut%0d", d), 32'(rd_busy(d)), 0);
      chk($sformatf("rst_drop_dut%0d", d), 32'(rd_drop(d)), 0);
    end
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    @(negedge clk);
    chk("ready_first_edge_dut0", 32'(tready0), 1);
    chk("ready_first_edge_dut1", 32'(tready1), 1);

    send(0, 'h7FFF, 0);
    send(0, -2174, 0);
    send(0, 'h7FFF, 1);
    repeat (3 * frame_len(0)) @(negedge clk);
    chk("no_extra_frame_ready", 32'(tready0), 1);
    chk("no_extra_frame_queue", 32'(expq[0].size()), 0);

    send(0, 'h0000, 3);
    send(0, 'h0001, 0);

    repeat (3) send(0, int'($urandom_range(0, 65535)), 2);

    foreach (bvals[i]) send(1, bvals[i], 0);
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 65535));
      send(1, v, 0);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end

    repeat (2 * frame_len(0)) @(negedge clk);
    chk("final_queue_dut0", 32'(expq[0].size()), 0);
    chk("final_queue_dut1", 32'(expq[1].size()), 0);
    chk("final_drop_dut0", 32'(drop0), 255);
    chk("final_drop_dut1", 32'(drop1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
